// File: rtl/butterfly_pipe_if.sv
// butterfly_pipe_if: valid/ready sample stream for the radix-2 butterfly.
// master drives A/B/W/tags/out_ready/ovf_clr; slave returns X/Y/last/ovf_flag.
interface butterfly_pipe_if #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] A_r;
  logic signed [DATA_W-1:0] A_i;
  logic signed [DATA_W-1:0] B_r;
  logic signed [DATA_W-1:0] B_i;
  logic signed [TW_W-1:0]   W_R;
  logic signed [TW_W-1:0]   W_I;
  logic                     mode_dif;
  logic                     scale;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] X_r;
  logic signed [DATA_W-1:0] X_i;
  logic signed [DATA_W-1:0] Y_r;
  logic signed [DATA_W-1:0] Y_i;
  logic                     out_last;
  logic                     ovf_flag;
  logic                     ovf_clr;

  modport master (
    output in_valid, A_r, A_i, B_r, B_i,
    output W_R, W_I, mode_dif, scale, in_last,
    output out_ready, ovf_clr,
    input  in_ready, out_valid,
    input  X_r, X_i, Y_r, Y_i,
    input  out_last, ovf_flag
  );

  modport slave (
    input  in_valid, A_r, A_i, B_r, B_i,
    input  W_R, W_I, mode_dif, scale, in_last,
    input  out_ready, ovf_clr,
    output in_ready, out_valid,
    output X_r, X_i, Y_r, Y_i,
    output out_last, ovf_flag
  );
endinterface

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 3-stage radix-2 complex butterfly, DIT/DIF per sample.
// Ports: clk, reset (async, active-low), bus (butterfly_pipe_if.slave).
module butterfly_pipe #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int FRAC_W = 14
) (
  input logic           clk,
  input logic           reset,
  butterfly_pipe_if.slave bus
);
  localparam int S1W = DATA_W + 1;
  localparam int S2W = DATA_W + 2;
  localparam int S3W = DATA_W + 3;
  localparam int PW  = DATA_W + TW_W + 2;

  localparam logic signed [PW-1:0] RND =
    PW'(1) << (FRAC_W - 1);
  localparam logic signed [S3W-1:0] ONE = 1;
  localparam logic signed [S3W-1:0] MAXV =
    {{4{1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [S3W-1:0] MINV =
    {{4{1'b1}}, {(DATA_W-1){1'b0}}};

  typedef struct packed {
    logic dif;
    logic scl;
    logic last;
  } tag_t;

  function automatic logic hit(
    input logic signed [S3W-1:0] v
  );
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [DATA_W-1:0] clip(
    input logic signed [S3W-1:0] v
  );
    if (v > MAXV) return MAXV[DATA_W-1:0];
    if (v < MINV) return MINV[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  logic adv;
  logic v1, v2, v3;
  tag_t t1, t2;
  logic last3;

  logic signed [S1W-1:0]  a1_r, a1_i, b1_r, b1_i;
  logic signed [TW_W-1:0] w1_r, w1_i;
  logic signed [S2W-1:0]  a2_r, a2_i, p2_r, p2_i;
  logic signed [DATA_W-1:0] x_r, x_i, y_r, y_i;
  logic sat3;
  logic ovf;

  // one stall signal freezes every stage together
  assign adv          = !v3 || bus.out_ready;
  assign bus.in_ready = adv;

  // S1: DIT keeps A/B, DIF forms sum/difference
  logic signed [S1W-1:0] ea_r, ea_i, eb_r, eb_i;
  logic signed [S1W-1:0] s1a_r, s1a_i, s1b_r, s1b_i;

  assign ea_r = {bus.A_r[DATA_W-1], bus.A_r};
  assign ea_i = {bus.A_i[DATA_W-1], bus.A_i};
  assign eb_r = {bus.B_r[DATA_W-1], bus.B_r};
  assign eb_i = {bus.B_i[DATA_W-1], bus.B_i};

  always_comb begin
    s1a_r = ea_r;
    s1a_i = ea_i;
    s1b_r = eb_r;
    s1b_i = eb_i;
    if (bus.mode_dif) begin
      s1a_r = ea_r + eb_r;
      s1a_i = ea_i + eb_i;
      s1b_r = ea_r - eb_r;
      s1b_i = ea_i - eb_i;
    end
  end

  // S2: complex multiply of the second term, round half-up
  logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x;
  logic signed [PW-1:0] pr_f, pi_f;
  logic signed [S2W-1:0] s2p_r, s2p_i, s2a_r, s2a_i;

  assign br_x = {{(PW-S1W){b1_r[S1W-1]}}, b1_r};
  assign bi_x = {{(PW-S1W){b1_i[S1W-1]}}, b1_i};
  assign wr_x = {{(PW-TW_W){w1_r[TW_W-1]}}, w1_r};
  assign wi_x = {{(PW-TW_W){w1_i[TW_W-1]}}, w1_i};

  assign pr_f = br_x * wr_x - bi_x * wi_x;
  assign pi_f = br_x * wi_x + bi_x * wr_x;

  assign s2p_r = S2W'((pr_f + RND) >>> FRAC_W);
  assign s2p_i = S2W'((pi_f + RND) >>> FRAC_W);
  assign s2a_r = {a1_r[S1W-1], a1_r};
  assign s2a_i = {a1_i[S1W-1], a1_i};

  // S3: combine, optional halving, saturate
  logic signed [S3W-1:0] ea3_r, ea3_i, ep3_r, ep3_i;
  logic signed [S3W-1:0] xr, xi, yr, yi;
  logic sat_n;

  assign ea3_r = {a2_r[S2W-1], a2_r};
  assign ea3_i = {a2_i[S2W-1], a2_i};
  assign ep3_r = {p2_r[S2W-1], p2_r};
  assign ep3_i = {p2_i[S2W-1], p2_i};

  always_comb begin
    xr = ea3_r;
    xi = ea3_i;
    yr = ep3_r;
    yi = ep3_i;
    if (!t2.dif) begin
      xr = ea3_r + ep3_r;
      xi = ea3_i + ep3_i;
      yr = ea3_r - ep3_r;
      yi = ea3_i - ep3_i;
    end
    if (t2.scl) begin
      xr = (xr + ONE) >>> 1;
      xi = (xi + ONE) >>> 1;
      yr = (yr + ONE) >>> 1;
      yi = (yi + ONE) >>> 1;
    end
    sat_n = hit(xr) | hit(xi) | hit(yr) | hit(yi);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      t1    <= '0;
      t2    <= '0;
      last3 <= 1'b0;
      a1_r  <= '0;
      a1_i  <= '0;
      b1_r  <= '0;
      b1_i  <= '0;
      w1_r  <= '0;
      w1_i  <= '0;
      a2_r  <= '0;
      a2_i  <= '0;
      p2_r  <= '0;
      p2_i  <= '0;
      x_r   <= '0;
      x_i   <= '0;
      y_r   <= '0;
      y_i   <= '0;
      sat3  <= 1'b0;
    end else if (adv) begin
      v1    <= bus.in_valid;
      t1    <= '{bus.mode_dif, bus.scale, bus.in_last};
      a1_r  <= s1a_r;
      a1_i  <= s1a_i;
      b1_r  <= s1b_r;
      b1_i  <= s1b_i;
      w1_r  <= bus.W_R;
      w1_i  <= bus.W_I;
      v2    <= v1;
      t2    <= t1;
      a2_r  <= s2a_r;
      a2_i  <= s2a_i;
      p2_r  <= s2p_r;
      p2_i  <= s2p_i;
      v3    <= v2;
      last3 <= t2.last;
      x_r   <= clip(xr);
      x_i   <= clip(xi);
      y_r   <= clip(yr);
      y_i   <= clip(yi);
      sat3  <= sat_n;
    end
  end

  // set beats clear when both land on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (v3 && bus.out_ready && sat3) begin
      ovf <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  assign bus.out_valid = v3;
  assign bus.out_last  = last3;
  assign bus.X_r       = x_r;
  assign bus.X_i       = x_i;
  assign bus.Y_r       = y_r;
  assign bus.Y_i       = y_i;
  assign bus.ovf_flag  = ovf;
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: directed + soak bench for butterfly_pipe.
// Expected samples are queued at acceptance and checked by a monitor.
module tb_butterfly_pipe;
  localparam int DATA_W = 16;
  localparam int TW_W   = 16;
  localparam int FRAC_W = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  butterfly_pipe_if #(.DATA_W(DATA_W), .TW_W(TW_W)) bus();

  butterfly_pipe #(
    .DATA_W(DATA_W),
    .TW_W(TW_W),
    .FRAC_W(FRAC_W)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus)
  );

  typedef struct {
    int xr;
    int xi;
    int yr;
    int yi;
    bit last;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  bit pdone;

  task automatic chk(string name, longint act, longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(int xr, int xi, int yr, int yi, bit l);
    exp_t e;
    e.xr = xr;
    e.xi = xi;
    e.yr = yr;
    e.yi = yi;
    e.last = l;
    return e;
  endfunction

  function automatic longint wrap18(longint v);
    longint m;
    m = v & ((64'sd1 <<< (DATA_W+2)) - 1);
    if (m >= (64'sd1 <<< (DATA_W+1))) m = m - (64'sd1 <<< (DATA_W+2));
    return m;
  endfunction

  function automatic int sat16(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic longint half(longint v, bit s);
    if (s) return (v + 1) >>> 1;
    return v;
  endfunction

  // reference butterfly in plain integer arithmetic
  function automatic exp_t model(int ar, int ai, int br, int bi,
                                 int wr, int wi, bit dif, bit scl,
                                 bit l);
    longint tr, ti, mr, mi, pr, pi, xr, xi, yr, yi;
    if (dif) begin
      tr = ar + br;
      ti = ai + bi;
      mr = ar - br;
      mi = ai - bi;
    end else begin
      tr = ar;
      ti = ai;
      mr = br;
      mi = bi;
    end
    pr = wrap18((mr * wr - mi * wi + 8192) >>> FRAC_W);
    pi = wrap18((mr * wi + mi * wr + 8192) >>> FRAC_W);
    if (dif) begin
      xr = tr;
      xi = ti;
      yr = pr;
      yi = pi;
    end else begin
      xr = tr + pr;
      xi = ti + pi;
      yr = tr - pr;
      yi = ti - pi;
    end
    return mk(sat16(half(xr, scl)), sat16(half(xi, scl)),
              sat16(half(yr, scl)), sat16(half(yi, scl)), l);
  endfunction

  // monitor: handshake rule, hold stability, scoreboard
  bit stalled;
  logic signed [DATA_W-1:0] px_r, px_i, py_r, py_i;
  logic plast;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", bus.in_ready,
          !(bus.out_valid && !bus.out_ready));
      if (stalled && bus.out_valid) begin
        chk("hold_x_r", bus.X_r, px_r);
        chk("hold_y_i", bus.Y_i, py_i);
        chk("hold_x_i", bus.X_i, px_i);
        chk("hold_y_r", bus.Y_r, py_r);
        chk("hold_last", bus.out_last, plast);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out actual=1 required=0");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("x_r", bus.X_r, e.xr);
          chk("x_i", bus.X_i, e.xi);
          chk("y_r", bus.Y_r, e.yr);
          chk("y_i", bus.Y_i, e.yi);
          chk("last", bus.out_last, e.last);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      px_r = bus.X_r;
      px_i = bus.X_i;
      py_r = bus.Y_r;
      py_i = bus.Y_i;
      plast = bus.out_last;
    end else begin
      stalled = 1'b0;
    end
  end

  // called just after a rising edge; returns just after the accept edge
  task automatic send(int ar, int ai, int br, int bi, int wr, int wi,
                      bit dif, bit scl, bit l, exp_t e);
    bus.in_valid = 1'b1;
    bus.A_r = 16'(ar);
    bus.A_i = 16'(ai);
    bus.B_r = 16'(br);
    bus.B_i = 16'(bi);
    bus.W_R = 16'(wr);
    bus.W_I = 16'(wi);
    bus.mode_dif = dif;
    bus.scale = scl;
    bus.in_last = l;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("accept_timeout", 0, 1);
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (q.size() == 0) break;
      cyc(1);
    end
    chk("drain", q.size(), 0);
    cyc(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit got;
    bus.in_valid = 1'b0;
    bus.A_r = '0;
    bus.A_i = '0;
    bus.B_r = '0;
    bus.B_i = '0;
    bus.W_R = '0;
    bus.W_I = '0;
    bus.mode_dif = 1'b0;
    bus.scale = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    bus.ovf_clr = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ovf", bus.ovf_flag, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_x_r", bus.X_r, 0);
    chk("rst_y_r", bus.Y_r, 0);
    cyc(2);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    // DIT with W = -1.0
    send(4, 0, 8, 0, -16384, 0, 0, 0, 0, mk(-4, 0, 12, 0, 0));
    drain();
    chk("ovf_after_t1", bus.ovf_flag, 0);

    // DIF with W = -1.0, then W = j
    send(4, 0, 8, 0, -16384, 0, 1, 0, 0, mk(12, 0, 4, 0, 0));
    send(1, 2, 3, 4, 0, 16384, 1, 0, 0, mk(4, 6, 2, -2, 0));
    drain();

    // scaling with half-up rounding
    send(5, 0, 2, 0, 16384, 0, 0, 1, 0, mk(4, 0, 2, 0, 0));
    send(-5, 0, 0, 0, 16384, 0, 0, 1, 0, mk(-2, 0, -2, 0, 0));
    drain();
    chk("ovf_before_sat", bus.ovf_flag, 0);

    // saturation, sticky flag and clear
    send(32767, 0, 32767, 0, 16384, 0, 0, 0, 0,
         mk(32767, 0, 0, 0, 0));
    drain();
    chk("ovf_set", bus.ovf_flag, 1);
    bus.ovf_clr = 1'b1;
    cyc(1);
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared", bus.ovf_flag, 0);

    // set and clear on the same edge
    bus.ovf_clr = 1'b1;
    send(32767, 0, 32767, 0, 16384, 0, 0, 0, 0,
         mk(32767, 0, 0, 0, 0));
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("setclr_seen", got, 1);
    chk("ovf_pre_setclr", bus.ovf_flag, 0);
    @(posedge clk);
    #1;
    chk("ovf_setclr", bus.ovf_flag, 1);
    cyc(1);
    bus.ovf_clr = 1'b0;
    chk("ovf_clr_hold", bus.ovf_flag, 0);
    drain();

    // backpressure: 6 samples, out_ready low for 5 cycles
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(i*100 + 1, i, i*10, -i, 16384, 0, 0, 0, i == 5,
               mk(i*110 + 1, 0, i*90 + 1, 2*i, i == 5));
      end
      begin
        cyc(3);
        bus.out_ready = 1'b0;
        cyc(5);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // random soak against the integer model
    pdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int ar, ai, br, bi, wr, wi;
          bit dif, scl, l;
          ar = $urandom_range(0, 65535) - 32768;
          ai = $urandom_range(0, 65535) - 32768;
          br = $urandom_range(0, 65535) - 32768;
          bi = $urandom_range(0, 65535) - 32768;
          wr = $urandom_range(0, 65535) - 32768;
          wi = $urandom_range(0, 65535) - 32768;
          dif = 1'($urandom_range(0, 1));
          scl = 1'($urandom_range(0, 1));
          l = 1'($urandom_range(0, 1));
          send(ar, ai, br, bi, wr, wi, dif, scl, l,
               model(ar, ai, br, bi, wr, wi, dif, scl, l));
          cyc($urandom_range(0, 2));
        end
        pdone = 1'b1;
      end
      begin
        for (int n = 0; n < 3000; n++) begin
          if (pdone && q.size() == 0) break;
          cyc(1);
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // reset with three samples in flight
    bus.out_ready = 1'b0;
    send(1, 0, 1, 0, 16384, 0, 0, 0, 0, mk(2, 0, 0, 0, 0));
    send(2, 0, 1, 0, 16384, 0, 0, 0, 0, mk(3, 0, 1, 0, 0));
    send(3, 0, 1, 0, 16384, 0, 0, 0, 1, mk(4, 0, 2, 0, 1));
    cyc(1);
    chk("pre_rst_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_last", bus.out_last, 0);
    q.delete();
    cyc(2);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cyc(1);
      chk("no_stale", bus.out_valid, 0);
    end

    // latency after reset
    send(7, 0, 3, 0, 16384, 0, 0, 0, 1, mk(10, 0, 4, 0, 1));
    chk("lat_1", bus.out_valid, 0);
    cyc(1);
    chk("lat_2", bus.out_valid, 0);
    cyc(1);
    chk("lat_3", bus.out_valid, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
